axi_refill_rd_master: RTL and testbench

- AXI4 read-burst master between the cache miss logic and the memory-side AXI slave.
- Accepts one cache-line refill request and issues a single INCR burst of LINE_BEATS 64-bit beats.
- Assembles the returned beats into a line buffer and hands the whole line back to the cache through a valid/ready response port.
- Only one transaction is in flight at a time; there is no write channel.

---
 rtl/axi_pkg.sv | 19 +
 rtl/axi_refill_rd_master.sv | 130 +++++++++++++
 tb/tb_axi_refill_rd_master.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings and the refill master state type.
//   AXI_BURST_INCR / AXI_SIZE_8B : constant AR channel fields
//   RESP_OKAY / RESP_SLVERR      : rresp encodings
//   refill_state_e               : refill master FSM states
package axi_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
   localparam logic [1:0] RESP_OKAY      = 2'b00;
   localparam logic [1:0] RESP_SLVERR    = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      AR,
      DATA,
      RESP
   } refill_state_e;

endpackage

// File: rtl/axi_refill_rd_master.sv
// AXI4 read-burst master for cache-line refills.
// Takes one miss address, issues a single INCR burst of LINE_BEATS 64-bit
// beats from the line-aligned address, collects the beats into a line buffer
// and returns the whole line (plus an error flag) on a valid/ready port.
//   clk, rst                      : clock, async active-high reset
//   req_valid/req_ready/req_addr  : refill request from the miss logic
//   resp_valid/resp_ready         : line hand-back to the cache
//   resp_line, resp_err           : assembled line (beat 0 in low bits), error
//   ar*                           : AXI read address channel
//   r*                            : AXI read data channel
module axi_refill_rd_master
   import axi_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 64,
   parameter int LINE_BEATS = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   input  logic [ADDR_W-1:0]            req_addr,
   output logic                         req_ready,
   output logic                         resp_valid,
   output logic [LINE_BEATS*DATA_W-1:0] resp_line,
   output logic                         resp_err,
   input  logic                         resp_ready,
   output logic [ADDR_W-1:0]            araddr,
   output logic                         arvalid,
   output logic [1:0]                   arburst,
   output logic [7:0]                   arlen,
   output logic [2:0]                   arsize,
   input  logic                         arready,
   input  logic [DATA_W-1:0]            rdata,
   input  logic [1:0]                   rresp,
   input  logic                         rvalid,
   input  logic                         rlast,
   output logic                         rready
);

   localparam int IDX_W      = $clog2(LINE_BEATS);
   // One extra bit so the counter can sit at LINE_BEATS while surplus beats drain.
   localparam int CNT_W      = IDX_W + 1;
   localparam int LINE_BYTES = LINE_BEATS * 8;

   localparam logic [CNT_W-1:0]  BEATS_C = CNT_W'(LINE_BEATS);
   localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(LINE_BEATS - 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

   refill_state_e state, state_nxt;

   logic [CNT_W-1:0]                    beat_cnt;
   logic                                err;
   logic [LINE_BEATS-1:0][DATA_W-1:0]   line_q;
   logic                                beat_bad;

   assign arburst   = AXI_BURST_INCR;
   assign arlen     = 8'(LINE_BEATS - 1);
   assign arsize    = AXI_SIZE_8B;
   assign resp_line = line_q;
   assign resp_err  = err;

   // Bad beat: slave error, a surplus beat past the line, or rlast on the wrong beat.
   assign beat_bad = (rresp != RESP_OKAY) || (beat_cnt == BEATS_C) ||
                     (rlast && (beat_cnt != LAST_C));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Handshake outputs decode straight from the state register.
   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      arvalid    = 1'b0;
      rready     = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = AR;
         end
         AR: begin
            arvalid = 1'b1;
            if (arready) state_nxt = DATA;
         end
         DATA: begin
            rready = 1'b1;
            if (rvalid && rlast) state_nxt = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Line buffer is only written in DATA, so it holds still through RESP.
   // Slots not reached by a short burst keep whatever the previous line left.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         araddr   <= '0;
         beat_cnt <= '0;
         err      <= 1'b0;
         line_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  araddr   <= req_addr & LINE_MASK;
                  beat_cnt <= '0;
                  err      <= 1'b0;
               end
            end
            DATA: begin
               if (rvalid) begin
                  if (beat_cnt < BEATS_C) begin
                     line_q[beat_cnt[IDX_W-1:0]] <= rdata;
                     beat_cnt <= beat_cnt + 1'b1;
                  end
                  if (beat_bad) err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_refill_rd_master.sv
// Self-checking bench for axi_refill_rd_master (LINE_BEATS=4, 64-bit data).
// A transaction-level model tracks what the cache has asked for and what the
// slave has delivered; a negedge process checks the DUT against it every cycle.
// Directed tasks act as the memory slave and cache, and pin the model with
// hand-computed lines, error flags and latencies.
module tb_axi_refill_rd_master;
   import axi_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready;
   logic [31:0]   req_addr;
   logic          resp_valid, resp_err, resp_ready;
   logic [255:0]  resp_line;
   logic [31:0]   araddr;
   logic          arvalid, arready;
   logic [1:0]    arburst;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [63:0]   rdata;
   logic [1:0]    rresp;
   logic          rvalid, rlast, rready;

   axi_refill_rd_master #(.ADDR_W(32), .DATA_W(64), .LINE_BEATS(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_line(resp_line), .resp_err(resp_err),
      .resp_ready(resp_ready),
      .araddr(araddr), .arvalid(arvalid), .arburst(arburst), .arlen(arlen),
      .arsize(arsize), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   task automatic summary();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   endtask

   // ---------------- model ----------------
   logic        m_busy, m_ar, m_last, m_bad;
   int          m_n;
   logic [31:0] m_araddr;
   logic [63:0] m_slot [4];

   always @(negedge clk) begin
      if (rst) begin
         m_busy = 0; m_ar = 0; m_last = 0; m_bad = 0; m_n = 0; m_araddr = '0;
         for (int i = 0; i < 4; i++) m_slot[i] = '0;
      end else begin
         chk("one_phase", 256'($countones({req_ready, arvalid, rready, resp_valid})), 256'd1);
         if (req_ready) chk("req_ready_busy", 256'(m_busy), 256'd0);
         if (arvalid) begin
            chk("arvalid_phase", 256'({m_busy, m_ar}), 256'b10);
            chk("araddr", 256'(araddr), 256'(m_araddr));
            chk("arlen", 256'(arlen), 256'd3);
            chk("arsize", 256'(arsize), 256'd3);
            chk("arburst", 256'(arburst), 256'd1);
         end
         if (rready) chk("rready_phase", 256'({m_busy, m_ar, m_last}), 256'b110);
         if (resp_valid) begin
            chk("resp_phase", 256'({m_busy, m_last}), 256'b11);
            chk("resp_line", resp_line, {m_slot[3], m_slot[2], m_slot[1], m_slot[0]});
            chk("resp_err", 256'(resp_err), 256'(m_bad || (m_n != 4)));
         end
         // Handshakes presented now complete at the coming posedge.
         if (req_valid && req_ready) begin
            m_busy = 1; m_ar = 0; m_last = 0; m_bad = 0; m_n = 0;
            m_araddr = req_addr & ~32'h1F;
         end
         if (arvalid && arready) m_ar = 1;
         if (rvalid && rready) begin
            if (m_n < 4) m_slot[m_n] = rdata;
            if (rresp != RESP_OKAY) m_bad = 1;
            if (rlast) m_last = 1;
            m_n++;
         end
         if (resp_valid && resp_ready) m_busy = 0;
      end
   end

   // ---------------- slave / cache driver ----------------
   int          req_cyc, ar_cyc, resp_cyc;
   logic [31:0] got_araddr;
   logic [255:0] got_line;
   logic        got_err;

   task automatic wait_sig(input int which);
      bit ok = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         case (which)
            0:       ok = req_ready;
            1:       ok = arvalid;
            2:       ok = rready;
            default: ok = resp_valid;
         endcase
         if (ok) break;
      end
      if (!ok) begin
         n_chk++; n_fail++;
         $display("FAIL timeout: handshake %0d never came, got 0 expected 1", which);
         summary();
      end
   endtask

   task automatic run_line(input logic [31:0] addr, input int nbeats, input int bad_beat,
                           input int ar_dly, input int gap, input int resp_dly,
                           input logic [63:0] dbase, input int rst_after,
                           input bit hold_req, input bit keep_rr);
      req_valid = 1; req_addr = addr;
      wait_sig(0); req_cyc = cyc;
      @(posedge clk); #1;
      // Optionally keep offering a different request while busy; it must not be taken.
      req_valid = hold_req; req_addr = addr ^ 32'h4000;
      arready = 0;
      repeat (ar_dly) begin @(posedge clk); #1; end
      arready = 1;
      wait_sig(1); ar_cyc = cyc; got_araddr = araddr;
      @(posedge clk); #1;
      arready = 0;
      for (int i = 0; i < nbeats; i++) begin
         if (gap > 0) begin
            rvalid = 0;
            repeat (gap) begin @(posedge clk); #1; end
         end
         rvalid = 1; rdata = dbase + 64'(i);
         rresp = (i == bad_beat) ? RESP_SLVERR : RESP_OKAY;
         rlast = (i == nbeats - 1);
         wait_sig(2);
         @(posedge clk); #1;
         if (rst_after == i + 1) begin
            rvalid = 0; rlast = 0; rresp = RESP_OKAY; req_valid = 0;
            rst = 1; #1;
            chk("rst_arvalid", 256'(arvalid), 256'd0);
            chk("rst_rready", 256'(rready), 256'd0);
            chk("rst_resp_valid", 256'(resp_valid), 256'd0);
            chk("rst_req_ready", 256'(req_ready), 256'd1);
            @(posedge clk); #1;
            rst = 0;
            return;
         end
      end
      rvalid = 0; rlast = 0; rresp = RESP_OKAY;
      resp_ready = (resp_dly == 0);
      wait_sig(3); resp_cyc = cyc; got_line = resp_line; got_err = resp_err;
      if (resp_dly > 0) begin
         repeat (resp_dly) begin @(posedge clk); #1; end
         resp_ready = 1;
         wait_sig(3); resp_cyc = cyc;
      end
      @(posedge clk); #1;
      resp_ready = keep_rr; req_valid = 0;
   endtask

   int resp_cyc1;

   initial begin
      rst = 1; req_valid = 0; req_addr = '0; resp_ready = 0; arready = 0;
      rdata = '0; rresp = RESP_OKAY; rvalid = 0; rlast = 0;
      repeat (3) @(posedge clk); #1;
      chk("reset_arvalid", 256'(arvalid), 256'd0);
      chk("reset_rready", 256'(rready), 256'd0);
      chk("reset_resp_valid", 256'(resp_valid), 256'd0);
      chk("reset_resp_err", 256'(resp_err), 256'd0);
      chk("reset_araddr", 256'(araddr), 256'd0);
      chk("reset_resp_line", resp_line, 256'd0);
      chk("reset_req_ready", 256'(req_ready), 256'd1);
      rst = 0;

      // Stray slave activity while idle must be ignored.
      arready = 1; rvalid = 1; rlast = 1; rdata = 64'hDEAD;
      repeat (3) begin
         @(posedge clk); #1;
         chk("stray_rready", 256'(rready), 256'd0);
         chk("stray_arvalid", 256'(arvalid), 256'd0);
      end
      arready = 0; rvalid = 0; rlast = 0; rdata = '0;

      // Basic refill with latency.
      run_line(32'h8000_0014, 4, -1, 0, 0, 0, 64'h11, 0, 0, 0);
      chk("basic_araddr", 256'(got_araddr), 256'h8000_0000);
      chk("basic_line", got_line, {64'h14, 64'h13, 64'h12, 64'h11});
      chk("basic_err", 256'(got_err), 256'd0);
      chk("basic_ar_cycle", 256'(ar_cyc - req_cyc), 256'd1);
      chk("basic_resp_cycle", 256'(resp_cyc - req_cyc), 256'd6);

      // Backpressure everywhere plus a competing request while busy.
      run_line(32'h1234_5678, 4, -1, 3, 2, 5, 64'hA0, 0, 1, 0);
      chk("bp_araddr", 256'(got_araddr), 256'h1234_5660);
      chk("bp_line", got_line, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
      chk("bp_err", 256'(got_err), 256'd0);

      // Slave error on beat 2.
      run_line(32'h0000_0040, 4, 2, 0, 0, 0, 64'h200, 0, 0, 0);
      chk("slverr_line", got_line, {64'h203, 64'h202, 64'h201, 64'h200});
      chk("slverr_err", 256'(got_err), 256'd1);

      // Early rlast after 2 beats: upper slots keep the previous line.
      run_line(32'h0000_0080, 2, -1, 0, 0, 0, 64'h300, 0, 0, 0);
      chk("short_line", got_line, {64'h203, 64'h202, 64'h301, 64'h300});
      chk("short_err", 256'(got_err), 256'd1);

      // Six-beat burst: only four stored, rready held until rlast.
      run_line(32'h0000_00C0, 6, -1, 0, 0, 0, 64'h400, 0, 0, 0);
      chk("long_line", got_line, {64'h403, 64'h402, 64'h401, 64'h400});
      chk("long_err", 256'(got_err), 256'd1);

      // Reset in the middle of DATA, then a clean refill.
      run_line(32'h0000_0500, 4, -1, 0, 0, 0, 64'h500, 2, 0, 0);
      run_line(32'h0000_0600, 4, -1, 0, 0, 0, 64'h600, 0, 0, 0);
      chk("postrst_araddr", 256'(got_araddr), 256'h600);
      chk("postrst_line", got_line, {64'h603, 64'h602, 64'h601, 64'h600});
      chk("postrst_err", 256'(got_err), 256'd0);

      // Back-to-back with resp_ready tied high.
      run_line(32'h0000_0100, 4, -1, 0, 0, 0, 64'h700, 0, 0, 1);
      resp_cyc1 = resp_cyc;
      run_line(32'h0000_0120, 4, -1, 0, 0, 0, 64'h710, 0, 0, 1);
      resp_ready = 0;
      chk("b2b_ar_gap", 256'(ar_cyc - resp_cyc1), 256'd2);
      chk("b2b_araddr", 256'(got_araddr), 256'h120);
      chk("b2b_line", got_line, {64'h713, 64'h712, 64'h711, 64'h710});

      repeat (3) @(posedge clk);
      summary();
   end

endmodule
